audio_framer: RTL and testbench
===============================

AUDIO_FRAMER -- requirements
Module: audio_framer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, meaning the number of PCM channels packed per strobe (legal range 1..16).
REQ-002 The block SHALL have parameter SPF, default 32, meaning the number of sample strobes per frame.
REQ-003 The block SHALL have parameter HDR_BYTES, default 14, meaning the bytes reserved at each buffer base for the Ethernet header (never written by this block).
REQ-004 The block SHALL have parameter ADDR_W, default 11, meaning the BRAM byte-address width; buffer 0 base = 0, buffer 1 base = 2^(ADDR_W-1).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port pcm_stb, input, 1 bit, a one-cycle strobe marking a new sample set.
REQ-008 The block SHALL have port pcm, input, 16*CHANNELS bits, signed samples; channel k at bits [16k+15:16k].
REQ-009 The block SHALL have ports bram_wr_en (output, 1 bit), bram_wr_addr (output, ADDR_W bits) and bram_wr_data (output, 8 bits), a registered byte write port.
REQ-010 The block SHALL have ports eth_start (output, 1 bit), a one-cycle transmit request, and eth_buf (output, 1 bit), the buffer to transmit, valid while eth_start is high and held afterwards.
REQ-011 The block SHALL have port eth_busy, input, 1 bit; when high, the transmitter is reading buffer eth_buf.
REQ-012 The block SHALL have ports overrun (output, 1 bit), a sticky error flag, and ovr_clr (input, 1 bit), which clears it.

Function
REQ-013 States SHALL be IDLE, SEQ_LO, SEQ_HI, WR_LO, WR_HI, DONE; the reset state is IDLE.
REQ-014 pcm_stb in IDLE SHALL snapshot pcm into an internal register and set ch = 0; transition to SEQ_LO if sample index = 0 and the sequence option is compiled in, else to WR_LO.
REQ-015 WR_LO SHALL write the snapshot low byte of channel ch; WR_HI SHALL write its high byte, then ch++ and return to WR_LO, or go to DONE when ch = CHANNELS-1 (little-endian, one byte per cycle).
REQ-016 The byte address SHALL equal base(wbuf) + HDR_BYTES + SEQ_BYTES + 2*(idx*CHANNELS + ch) + {0,1}, where SEQ_BYTES is 2 or 0.
REQ-017 Latency SHALL be: pcm_stb at cycle N gives the first sample byte with bram_wr_en = 1 at N+1 (N+3 with sequence bytes), and the last at N+2*CHANNELS (+2); bram_wr_en SHALL be 0 in all other cycles.
REQ-018 DONE SHALL increment idx; if idx = SPF-1, set idx = 0 and evaluate frame completion; then go to IDLE.
REQ-019 On frame completion with eth_busy = 0, the block SHALL pulse eth_start for one cycle, set eth_buf = wbuf, and toggle wbuf (ping-pong).
REQ-020 On frame completion with eth_busy = 1, the block SHALL not pulse eth_start, SHALL keep wbuf (frame dropped and overwritten), and SHALL set overrun.
REQ-021 pcm_stb arriving outside IDLE SHALL be ignored and SHALL set overrun.
REQ-022 ovr_clr SHALL clear overrun next cycle; a simultaneous set SHALL win over the clear.
REQ-023 idx SHALL be clog2(SPF) bits wide and ch SHALL be 4 bits wide; no other counter may wrap except the sequence counter, which wraps 0xFFFF to 0.

Reset
REQ-024 With rst_n = 0, the block SHALL immediately force: state IDLE, idx 0, ch 0, wbuf 0, eth_buf 0, seq 0, bram_wr_en 0, bram_wr_addr 0, bram_wr_data 0, eth_start 0, overrun 0.
REQ-025 Reset asserted mid-frame SHALL abandon the partial frame; after release, writing SHALL restart at buffer 0, idx 0.

Configuration
REQ-026 With FRAMER_SEQNUM_EN defined, each frame SHALL begin with a 16-bit sequence number (low byte, then high byte) at base + HDR_BYTES, and seq SHALL increment on each eth_start only.
REQ-027 Without FRAMER_SEQNUM_EN, SEQ_LO and SEQ_HI SHALL be absent, SEQ_BYTES SHALL be 0, and samples SHALL start at base + HDR_BYTES.

Verification
REQ-028 CHANNELS=2, pcm={16'h1234, 16'hABCD}, one strobe -> writes 0x0E=CD, 0x0F=AB, 0x10=34, 0x11=12 on consecutive cycles starting at N+1 (macro off).
REQ-029 32 strobes spaced 10 cycles apart, eth_busy = 0 -> one eth_start pulse with eth_buf = 0; the next frame writes from 0x40E.
REQ-030 Frame completion with eth_busy = 1 -> no eth_start, overrun = 1, the next frame rewrites 0x00E in the same buffer.
REQ-031 Second pcm_stb 2 cycles after the first, CHANNELS=2 -> ignored, overrun = 1; ovr_clr -> overrun = 0.
REQ-032 FRAMER_SEQNUM_EN, three frames -> bytes 0x0E/0x0F = 00 00, then 0x40E/0x40F = 01 00, then 0x0E/0x0F = 02 00.
REQ-033 rst_n low at strobe 5 of a frame -> outputs are 0 without a clock edge; after release, the first strobe writes from 0x00E.

Source files
------------

// File: rtl/audio_framer.sv
// audio_framer: packs PCM sample sets into a ping-pong pair of Ethernet
// frame buffers in a byte-wide BRAM and requests transmission of each
// completed frame.
//
// Each buffer starts with HDR_BYTES reserved for the Ethernet header, which
// this block never writes. Samples are written little-endian, one byte per
// cycle, channel 0 first.
//
// Optional feature: define FRAMER_SEQNUM_EN to prefix every frame with a
// 16-bit sequence number (low byte first), placed directly after the header.
// The sequence number advances only when a frame is actually handed to the
// transmitter. Without the macro, samples start right after the header.
module audio_framer #(
    parameter int CHANNELS  = 2,
    parameter int SPF       = 32,
    parameter int HDR_BYTES = 14,
    parameter int ADDR_W    = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pcm_stb,
    input  logic [16*CHANNELS-1:0]  pcm,
    output logic                    bram_wr_en,
    output logic [ADDR_W-1:0]       bram_wr_addr,
    output logic [7:0]              bram_wr_data,
    output logic                    eth_start,
    output logic                    eth_buf,
    input  logic                    eth_busy,
    output logic                    overrun,
    input  logic                    ovr_clr
);

    localparam int IDX_W = (SPF > 1) ? $clog2(SPF) : 1;
`ifdef FRAMER_SEQNUM_EN
    localparam int SEQ_BYTES = 2;
`else
    localparam int SEQ_BYTES = 0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
`ifdef FRAMER_SEQNUM_EN
        SEQ_LO = 3'd1,
        SEQ_HI = 3'd2,
`endif
        WR_LO  = 3'd3,
        WR_HI  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                  state_r;
    logic [16*CHANNELS-1:0]  snap_r;
    logic [IDX_W-1:0]        idx_r;
    logic [3:0]              ch_r;
    logic                    wbuf_r;
    logic                    eth_buf_r;
    logic                    eth_start_r;
    logic                    overrun_r;
    logic                    bram_wr_en_r;
    logic [ADDR_W-1:0]       bram_wr_addr_r;
    logic [7:0]              bram_wr_data_r;
`ifdef FRAMER_SEQNUM_EN
    logic [15:0]             seq_r;
`endif

    logic [ADDR_W-1:0]       base_s;
    logic [ADDR_W-1:0]       hdr_addr_s;
    logic [ADDR_W-1:0]       samp_addr_s;
    logic [31:0]             samp_off_s;
    logic [15:0]             samp_s;
    logic                    last_ch_s;
    logic                    last_idx_s;
    logic                    ovr_set_s;

    assign bram_wr_en   = bram_wr_en_r;
    assign bram_wr_addr = bram_wr_addr_r;
    assign bram_wr_data = bram_wr_data_r;
    assign eth_start    = eth_start_r;
    assign eth_buf      = eth_buf_r;
    assign overrun      = overrun_r;

    // Address of the current sample and the sequence slot, plus the channel mux.
    always_comb begin
        base_s      = {wbuf_r, {(ADDR_W-1){1'b0}}};
        hdr_addr_s  = base_s + ADDR_W'(HDR_BYTES);
        samp_off_s  = 32'(HDR_BYTES) + 32'(SEQ_BYTES)
                    + 32'd2 * (32'(idx_r) * 32'(CHANNELS) + 32'(ch_r));
        samp_addr_s = base_s + samp_off_s[ADDR_W-1:0];
        samp_s      = 16'd0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_r == 4'(k)) begin
                samp_s = snap_r[16*k +: 16];
            end else begin
                samp_s = samp_s;
            end
        end
        last_ch_s  = (ch_r == 4'(CHANNELS-1));
        last_idx_s = (idx_r == IDX_W'(SPF-1));
        // A strobe we cannot take, or a finished frame the transmitter is
        // still busy with, both flag overrun.
        ovr_set_s  = (pcm_stb && (state_r != IDLE))
                   || ((state_r == DONE) && last_idx_s && eth_busy);
    end

    // Framing state machine with registered BRAM, transmit and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            snap_r         <= '0;
            idx_r          <= '0;
            ch_r           <= 4'd0;
            wbuf_r         <= 1'b0;
            eth_buf_r      <= 1'b0;
            eth_start_r    <= 1'b0;
            overrun_r      <= 1'b0;
            bram_wr_en_r   <= 1'b0;
            bram_wr_addr_r <= '0;
            bram_wr_data_r <= 8'd0;
`ifdef FRAMER_SEQNUM_EN
            seq_r          <= 16'd0;
`endif
        end else begin
            bram_wr_en_r <= 1'b0;
            eth_start_r  <= 1'b0;

            // Set has priority so an error coinciding with a clear is not lost.
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end

            case (state_r)
                IDLE: begin
                    if (pcm_stb) begin
                        snap_r <= pcm;
                        ch_r   <= 4'd0;
`ifdef FRAMER_SEQNUM_EN
                        if (idx_r == IDX_W'(0)) begin
                            state_r <= SEQ_LO;
                        end else begin
                            state_r <= WR_LO;
                        end
`else
                        state_r <= WR_LO;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
`ifdef FRAMER_SEQNUM_EN
                SEQ_LO: begin
                    bram_wr_en_r   <= 1'b1;
                    bram_wr_addr_r <= hdr_addr_s;
                    bram_wr_data_r <= seq_r[7:0];
                    state_r        <= SEQ_HI;
                end
                SEQ_HI: begin
                    bram_wr_en_r   <= 1'b1;
                    bram_wr_addr_r <= hdr_addr_s + ADDR_W'(1);
                    bram_wr_data_r <= seq_r[15:8];
                    state_r        <= WR_LO;
                end
`endif
                WR_LO: begin
                    bram_wr_en_r   <= 1'b1;
                    bram_wr_addr_r <= samp_addr_s;
                    bram_wr_data_r <= samp_s[7:0];
                    state_r        <= WR_HI;
                end
                WR_HI: begin
                    bram_wr_en_r   <= 1'b1;
                    bram_wr_addr_r <= samp_addr_s + ADDR_W'(1);
                    bram_wr_data_r <= samp_s[15:8];
                    if (last_ch_s) begin
                        state_r <= DONE;
                    end else begin
                        ch_r    <= ch_r + 4'd1;
                        state_r <= WR_LO;
                    end
                end
                DONE: begin
                    if (last_idx_s) begin
                        idx_r <= '0;
                        if (!eth_busy) begin
                            eth_start_r <= 1'b1;
                            eth_buf_r   <= wbuf_r;
                            wbuf_r      <= ~wbuf_r;
`ifdef FRAMER_SEQNUM_EN
                            seq_r       <= seq_r + 16'd1;
`endif
                        end else begin
                            // Transmitter still owns the other buffer: drop
                            // this frame and overwrite it in place.
                            wbuf_r <= wbuf_r;
                        end
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_framer.sv
// Self-checking bench for audio_framer (default parameters). Expected BRAM
// writes are derived from the frame layout rules: buffer base, header gap,
// optional sequence slot, then little-endian samples in channel order.
module tb_audio_framer;

    localparam int C   = 2;
    localparam int SPF = 32;
    localparam int HDR = 14;
    localparam int AW  = 11;
`ifdef FRAMER_SEQNUM_EN
    localparam int SB = 2;
`else
    localparam int SB = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pcm_stb;
    logic [16*C-1:0]   pcm;
    logic              bram_wr_en;
    logic [AW-1:0]     bram_wr_addr;
    logic [7:0]        bram_wr_data;
    logic              eth_start;
    logic              eth_buf;
    logic              eth_busy;
    logic              overrun;
    logic              ovr_clr;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_idx;
    bit m_wbuf;
    bit m_ethbuf;
    bit m_ov;
    int m_seq;

    audio_framer #(
        .CHANNELS (C),
        .SPF      (SPF),
        .HDR_BYTES(HDR),
        .ADDR_W   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcm_stb     (pcm_stb),
        .pcm         (pcm),
        .bram_wr_en  (bram_wr_en),
        .bram_wr_addr(bram_wr_addr),
        .bram_wr_data(bram_wr_data),
        .eth_start   (eth_start),
        .eth_buf     (eth_buf),
        .eth_busy    (eth_busy),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx    = 0;
        m_wbuf   = 1'b0;
        m_ethbuf = 1'b0;
        m_ov     = 1'b0;
        m_seq    = 0;
    endtask

    // One clock: update the overrun model at the edge, then check outputs.
    task automatic tick_chk(input bit en, input logic [AW-1:0] a, input logic [7:0] d,
                            input bit st, input bit ovset);
        @(posedge clk);
        if (ovset) m_ov = 1'b1;
        else if (ovr_clr) m_ov = 1'b0;
        #1;
        chk("wr_en", bram_wr_en, en);
        if (en) begin
            chk("wr_addr", bram_wr_addr, a);
            chk("wr_data", bram_wr_data, d);
        end
        chk("eth_start", eth_start, st);
        chk("eth_buf", eth_buf, m_ethbuf);
        chk("overrun", overrun, m_ov);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_chk(1'b0, '0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        tick_chk(1'b0, '0, 8'h00, 1'b0, 1'b0);
        ovr_clr = 1'b0;
    endtask

    // One sample set. extra_at / clr_at: edge number (1 = accepting edge) at
    // which a stray strobe / an overrun clear is presented; 0 = never.
    task automatic do_strobe(input logic [31:0] data, input bit busy,
                             input int extra_at, input int clr_at);
        logic [AW-1:0] aq[$];
        logic [7:0]    dq[$];
        logic [AW-1:0] base;
        int            off;
        int            n;
        bit            last;
        bit            st;
        bit            en;
        base = m_wbuf ? 11'h400 : 11'h000;
        if (SB == 2 && m_idx == 0) begin
            aq.push_back(base + 11'(HDR));     dq.push_back(m_seq[7:0]);
            aq.push_back(base + 11'(HDR + 1)); dq.push_back(m_seq[15:8]);
        end
        for (int k = 0; k < C; k++) begin
            off = HDR + SB + 2 * (m_idx * C + k);
            aq.push_back(base + 11'(off));     dq.push_back(data[16*k +: 8]);
            aq.push_back(base + 11'(off + 1)); dq.push_back(data[16*k+8 +: 8]);
        end
        n    = aq.size();
        last = (m_idx == SPF - 1);
        st   = last && !busy;
        pcm      = data;
        eth_busy = busy;
        for (int k = 1; k <= n + 2; k++) begin
            pcm_stb = (k == 1) || (k == extra_at);
            ovr_clr = (k == clr_at);
            if (k == n + 2) begin
                m_idx = last ? 0 : m_idx + 1;
                if (st) begin
                    m_ethbuf = m_wbuf;
                    m_wbuf   = !m_wbuf;
                    m_seq    = (m_seq + 1) % 65536;
                end
            end
            en = (k >= 2) && (k <= n + 1);
            tick_chk(en, en ? aq[k-2] : 11'h000, en ? dq[k-2] : 8'h00,
                     (k == n + 2) && st,
                     ((k >= 2) && (k == extra_at)) || ((k == n + 2) && last && busy));
            // The snapshot must not follow later changes on pcm.
            if (k == 1) pcm = ~data;
        end
        pcm_stb  = 1'b0;
        ovr_clr  = 1'b0;
        eth_busy = 1'b0;
    endtask

    task automatic run_frame(input int ns, input bit busy_last);
        for (int i = 0; i < ns; i++) begin
            idle($urandom_range(0, 3));
            do_strobe($urandom, busy_last && (i == ns - 1), 0, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},   bram_wr_en,   32'd0);
        chk({tag, "_wr_addr"}, bram_wr_addr, 32'd0);
        chk({tag, "_wr_data"}, bram_wr_data, 32'd0);
        chk({tag, "_start"},   eth_start,    32'd0);
        chk({tag, "_eth_buf"}, eth_buf,      32'd0);
        chk({tag, "_overrun"}, overrun,      32'd0);
    endtask

    initial begin
        pcm_stb  = 1'b0;
        eth_busy = 1'b0;
        ovr_clr  = 1'b0;
        pcm      = '0;
        rst_n    = 1'b1;
        model_reset();

        // Asynchronous reset takes effect before any clock edge
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Frame A (buffer 0): directed first strobe, stray strobes, clears
        do_strobe(32'h1234ABCD, 1'b0, 0, 0);
        idle(2);
        do_strobe($urandom, 1'b0, 3, 0);
        clear_ovr();
        do_strobe($urandom, 1'b0, 4, 4);
        clear_ovr();
        run_frame(29, 1'b0);
        idle(3);

        // Frame B (buffer 1) completes while transmitter busy: dropped
        run_frame(32, 1'b1);
        idle(2);

        // Frame C rewrites buffer 1; reset lands in the middle of strobe 6
        run_frame(5, 1'b0);
        pcm     = $urandom;
        pcm_stb = 1'b1;
        @(posedge clk);
        #1 pcm_stb = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        model_reset();
        #1 rst_n = 1'b1;
        idle(2);

        // After reset: two full frames and the start of a third
        run_frame(32, 1'b0);
        idle(2);
        run_frame(32, 1'b0);
        idle(2);
        run_frame(1, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
